fpu_out_arb: RTL and testbench

//  Credit-based round-robin arbiter that shares the single FPU->CPX result port between the add, mul and div pipes.
//  It sits between the pipe stage-6/8 request signals and the output datapath mux.
//  It drives registered dest_rdy/req_thread to the mux and a one-hot per-core request to the CPX.
//  It tracks per-core CPX queue credits and back-pressures each losing or blocked pipe with a stall.

---
 rtl/fpu_out_arb.sv | 224 ++++++++++++++++++++++
 tb/tb_fpu_out_arb.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_out_arb.sv
// ---------------------------------------------------------------------------
// fpu_out_arb
//
// Credit-based round-robin arbiter for the single FPU->CPX result port.
// Three pipes compete for the port: add, mul and div. A pipe can be granted
// only when it is requesting and the destination core still has a free
// CPX input-queue entry. Among eligible pipes the winner is chosen
// round-robin, starting at the pipe after the previous winner, in the order
// ADD -> MUL -> DIV -> ADD.
//
// The winner is registered toward the output mux and the CPX, so those
// outputs appear one cycle after the request. Stalls are combinational, so
// a losing pipe learns in the same cycle that it must hold its result.
//
// Optional feature (define FPU_OUT_ARB_STARVE_EN):
//   Each pipe gets a 4-bit wait counter. The counter counts cycles in which
//   the pipe requested and stalled. It clears on a grant or when the request
//   drops. When a counter has saturated at 15 and that pipe is eligible, the
//   pipe wins ahead of round-robin. If several pipes are starved, the order
//   is div > mul > add. Without the macro, arbitration is pure round-robin.
//
// Parameters
//   CREDITS : CPX queue entries per core. This is the reset and maximum
//             credit value (1..7).
//   CW      : credit counter width; must be able to hold CREDITS.
//
// Ports
//   rclk            : clock
//   grst            : synchronous reset, active high
//   add/mul/div_req : pipe has a valid result this cycle
//   add/mul/div_id  : result ID; [2:0] dest core, [4:3] thread, [9:5] tag
//   cpx_fp_grant_cx : per-core credit return (may be multi-hot)
//   add/mul/div_stall : result not taken this cycle; pipe must hold it
//   fp_cpx_req_cq   : registered one-hot request to the destination core
//   dest_rdy        : registered one-hot winner {div,mul,add}
//   req_thread      : registered thread of the winner
//   req_tag         : registered tag of the winner
//   credit_err      : sticky; a credit came back while the counter was full
// ---------------------------------------------------------------------------
module fpu_out_arb #(
    parameter int CREDITS = 2,
    parameter int CW      = 3
) (
    input  logic       rclk,
    input  logic       grst,
    input  logic       add_req,
    input  logic       mul_req,
    input  logic       div_req,
    input  logic [9:0] add_id,
    input  logic [9:0] mul_id,
    input  logic [9:0] div_id,
    input  logic [7:0] cpx_fp_grant_cx,
    output logic       add_stall,
    output logic       mul_stall,
    output logic       div_stall,
    output logic [7:0] fp_cpx_req_cq,
    output logic [2:0] dest_rdy,
    output logic [1:0] req_thread,
    output logic [4:0] req_tag,
    output logic       credit_err
);

    typedef enum logic [1:0] {
        PIPE_ADD = 2'd0,
        PIPE_MUL = 2'd1,
        PIPE_DIV = 2'd2
    } pipe_e;

    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
    localparam logic [CW-1:0] CRED_ONE = CW'(1);

    // Pipe index 0 = add, 1 = mul, 2 = div, everywhere below.
    logic [2:0] req_vec;
    logic [9:0] pipe_id [3];

    logic [7:0] credit_nz;   // core has at least one free queue entry
    logic [7:0] err_set;     // return arrived while the core counter was full
    logic [2:0] elig;
    logic [2:0] rr_pick;
    logic [2:0] pick;
    logic [2:0] win;
    logic [9:0] win_id;
    logic       grant_any;
    logic [7:0] grant_cq;

    pipe_e rr_last_reg;
    pipe_e rr_last_next;

    assign req_vec    = {div_req, mul_req, add_req};
    assign pipe_id[0] = add_id;
    assign pipe_id[1] = mul_id;
    assign pipe_id[2] = div_id;

    // Eligibility uses the credit value at the start of the cycle. A credit
    // returned in the same cycle only becomes usable after the edge.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_elig
            assign elig[gi] = req_vec[gi] & credit_nz[pipe_id[gi][2:0]];
        end
    endgenerate

    // Round-robin: the search starts at the pipe after the last winner.
    always_comb begin
        rr_pick = 3'b000;
        case (rr_last_reg)
            PIPE_ADD: begin
                if (elig[1])      rr_pick = 3'b010;
                else if (elig[2]) rr_pick = 3'b100;
                else if (elig[0]) rr_pick = 3'b001;
            end
            PIPE_MUL: begin
                if (elig[2])      rr_pick = 3'b100;
                else if (elig[0]) rr_pick = 3'b001;
                else if (elig[1]) rr_pick = 3'b010;
            end
            default: begin
                if (elig[0])      rr_pick = 3'b001;
                else if (elig[1]) rr_pick = 3'b010;
                else if (elig[2]) rr_pick = 3'b100;
            end
        endcase
    end

`ifdef FPU_OUT_ARB_STARVE_EN
    logic [2:0] wait_full;
    logic [2:0] starved;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_wait
            logic [3:0] wait_reg;

            // Outside reset, "requesting and not winning" is exactly the
            // stall condition, so this counts stalled cycles.
            always_ff @(posedge rclk) begin
                if (grst || !req_vec[gi] || win[gi]) begin
                    wait_reg <= 4'd0;
                end else if (wait_reg != 4'hF) begin
                    wait_reg <= wait_reg + 4'd1;
                end
            end

            assign wait_full[gi] = (wait_reg == 4'hF);
        end
    endgenerate

    assign starved = wait_full & elig;

    // A starved pipe overrides round-robin; div has the highest priority.
    always_comb begin
        pick = rr_pick;
        if (starved[2])      pick = 3'b100;
        else if (starved[1]) pick = 3'b010;
        else if (starved[0]) pick = 3'b001;
    end
`else
    assign pick = rr_pick;
`endif

    // While in reset nothing is granted and nobody is told to stall.
    assign win = grst ? 3'b000 : pick;

    assign add_stall = req_vec[0] & ~win[0] & ~grst;
    assign mul_stall = req_vec[1] & ~win[1] & ~grst;
    assign div_stall = req_vec[2] & ~win[2] & ~grst;

    // win is one-hot or zero, so an AND-OR mux is sufficient. With no
    // winner, win_id is zero and so are the registered thread and tag.
    assign win_id = ({10{win[0]}} & add_id)
                  | ({10{win[1]}} & mul_id)
                  | ({10{win[2]}} & div_id);

    assign grant_any = |win;
    assign grant_cq  = grant_any ? (8'b1 << win_id[2:0]) : 8'b0;

    always_comb begin
        rr_last_next = rr_last_reg;
        if (win[0])      rr_last_next = PIPE_ADD;
        else if (win[1]) rr_last_next = PIPE_MUL;
        else if (win[2]) rr_last_next = PIPE_DIV;
    end

    // Per-core credit counters. When a grant and a return hit the same
    // core in the same cycle, they cancel. An underflow cannot happen,
    // because a grant requires a non-zero counter.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_credit
            logic [CW-1:0] credit_reg;

            always_ff @(posedge rclk) begin
                if (grst) begin
                    credit_reg <= CRED_MAX;
                end else if (grant_cq[gi] && !cpx_fp_grant_cx[gi]) begin
                    credit_reg <= credit_reg - CRED_ONE;
                end else if (!grant_cq[gi] && cpx_fp_grant_cx[gi] &&
                             (credit_reg != CRED_MAX)) begin
                    credit_reg <= credit_reg + CRED_ONE;
                end
            end

            assign credit_nz[gi] = (credit_reg != '0);
            assign err_set[gi]   = cpx_fp_grant_cx[gi] & ~grant_cq[gi] &
                                   (credit_reg == CRED_MAX);
        end
    endgenerate

    always_ff @(posedge rclk) begin
        if (grst) begin
            dest_rdy      <= 3'b000;
            fp_cpx_req_cq <= 8'h00;
            req_thread    <= 2'd0;
            req_tag       <= 5'd0;
            credit_err    <= 1'b0;
            rr_last_reg   <= PIPE_ADD;
        end else begin
            dest_rdy      <= win;
            fp_cpx_req_cq <= grant_cq;
            req_thread    <= win_id[4:3];
            req_tag       <= win_id[9:5];
            credit_err    <= credit_err | (|err_set);
            rr_last_reg   <= rr_last_next;
        end
    end

endmodule

// File: tb/tb_fpu_out_arb.sv
// ---------------------------------------------------------------------------
// tb_fpu_out_arb
//
// Directed testbench for fpu_out_arb with CREDITS=2. Inputs change 1 time
// unit after a rising edge. Stalls are sampled 1 time unit later. Registered
// outputs are sampled 1 time unit after the next rising edge.
// ---------------------------------------------------------------------------
module tb_fpu_out_arb;

    logic       rclk = 1'b0;
    logic       grst;
    logic       add_req, mul_req, div_req;
    logic [9:0] add_id, mul_id, div_id;
    logic [7:0] cpx_fp_grant_cx;
    logic       add_stall, mul_stall, div_stall;
    logic [7:0] fp_cpx_req_cq;
    logic [2:0] dest_rdy;
    logic [1:0] req_thread;
    logic [4:0] req_tag;
    logic       credit_err;

    int checks   = 0;
    int failures = 0;

    always #5 rclk = ~rclk;

    fpu_out_arb #(.CREDITS(2), .CW(3)) dut (
        .rclk            (rclk),
        .grst            (grst),
        .add_req         (add_req),
        .mul_req         (mul_req),
        .div_req         (div_req),
        .add_id          (add_id),
        .mul_id          (mul_id),
        .div_id          (div_id),
        .cpx_fp_grant_cx (cpx_fp_grant_cx),
        .add_stall       (add_stall),
        .mul_stall       (mul_stall),
        .div_stall       (div_stall),
        .fp_cpx_req_cq   (fp_cpx_req_cq),
        .dest_rdy        (dest_rdy),
        .req_thread      (req_thread),
        .req_tag         (req_tag),
        .credit_err      (credit_err)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    function automatic logic [9:0] mk_id(input int core, input int thread,
                                         input int tag);
        return {tag[4:0], thread[1:0], core[2:0]};
    endfunction

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    // Sample the combinational stalls after the inputs have settled.
    task automatic check_stall(input string tag, input logic [2:0] exp);
        #1;
        check({tag, ".stall"}, {div_stall, mul_stall, add_stall}, exp);
    endtask

    task automatic check_out(input string tag, input logic [2:0] dr,
                             input logic [7:0] cq, input logic [1:0] th,
                             input logic [4:0] tg);
        check({tag, ".dest_rdy"}, dest_rdy, dr);
        check({tag, ".cq"}, fp_cpx_req_cq, cq);
        check({tag, ".thread"}, req_thread, th);
        check({tag, ".tag"}, req_tag, tg);
    endtask

    initial begin
        logic [7:0] prev_cq;
        int w;

        grst = 1'b1;
        add_req = 1'b1; mul_req = 1'b0; div_req = 1'b0;
        add_id = mk_id(3, 2, 10); mul_id = '0; div_id = '0;
        cpx_fp_grant_cx = 8'h00;

        // Reset with a request pending: no grant and no stall.
        tick(); tick();
        check_stall("rst", 3'b000);
        check_out("rst", 3'b000, 8'h00, 2'd0, 5'd0);
        check("rst.err", credit_err, 1'b0);

        // Test 1: a lone add to core 3, thread 2.
        grst = 1'b0;
        check_stall("t1", 3'b000);
        tick();
        check_out("t1", 3'b001, 8'h08, 2'd2, 5'd10);
        add_req = 1'b0;
        check_stall("t1.idle", 3'b000);
        tick();
        check_out("t1.idle", 3'b000, 8'h00, 2'd0, 5'd0);

        // Test 2: all three pipes request different cores. Each credit is
        // returned one cycle after its grant. rr_last is ADD, so the grant
        // sequence is MUL, DIV, ADD, ...
        add_id = mk_id(0, 1, 1);
        mul_id = mk_id(1, 2, 2);
        div_id = mk_id(2, 3, 3);
        prev_cq = 8'h00;
        for (int i = 0; i < 6; i++) begin
            w = (i + 1) % 3;
            add_req = 1'b1; mul_req = 1'b1; div_req = 1'b1;
            cpx_fp_grant_cx = prev_cq;
            check_stall($sformatf("t2.c%0d", i), 3'b111 & ~(3'b001 << w));
            tick();
            check_out($sformatf("t2.c%0d", i), 3'b001 << w, 8'h01 << w,
                      2'(w + 1), 5'(w + 1));
            prev_cq = 8'h01 << w;
        end
        add_req = 1'b0; mul_req = 1'b0; div_req = 1'b0;
        cpx_fp_grant_cx = prev_cq;
        tick();
        cpx_fp_grant_cx = 8'h00;
        check("t2.err", credit_err, 1'b0);

        // Test 3: core 5 runs out of credit. A same-cycle return does not
        // help; the request is granted one cycle after the pulse.
        add_id = mk_id(5, 0, 21);
        add_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check_stall($sformatf("t3.g%0d", i), 3'b000);
            tick();
            check("t3.g.dest_rdy", dest_rdy, 3'b001);
        end
        for (int i = 0; i < 3; i++) begin
            check_stall($sformatf("t3.s%0d", i), 3'b001);
            tick();
            check("t3.s.dest_rdy", dest_rdy, 3'b000);
        end
        cpx_fp_grant_cx = 8'h20;
        check_stall("t3.pulse", 3'b001);
        tick();
        check("t3.pulse.dest_rdy", dest_rdy, 3'b000);
        cpx_fp_grant_cx = 8'h00;
        check_stall("t3.after", 3'b000);
        tick();
        check_out("t3.after", 3'b001, 8'h20, 2'd0, 5'd21);
        add_req = 1'b0;

        // Test 4: a grant and a return on core 0 in the same cycle cancel
        // out. Then an overflowing return sets the sticky error flag.
        add_id = mk_id(0, 0, 4);
        add_req = 1'b1;
        check_stall("t4.g0", 3'b000);
        tick();                                   // credit 2 -> 1
        check("t4.g0.dest_rdy", dest_rdy, 3'b001);
        cpx_fp_grant_cx = 8'h01;
        check_stall("t4.both", 3'b000);
        tick();                                   // credit stays 1
        check("t4.both.dest_rdy", dest_rdy, 3'b001);
        cpx_fp_grant_cx = 8'h00;
        check_stall("t4.g1", 3'b000);
        tick();                                   // credit 1 -> 0
        check("t4.g1.dest_rdy", dest_rdy, 3'b001);
        check_stall("t4.empty", 3'b001);
        tick();
        check("t4.empty.dest_rdy", dest_rdy, 3'b000);
        add_req = 1'b0;
        cpx_fp_grant_cx = 8'h01;
        tick();                                   // 0 -> 1
        check("t4.ret1.err", credit_err, 1'b0);
        tick();                                   // 1 -> 2
        check("t4.ret2.err", credit_err, 1'b0);
        tick();                                   // already at 2
        check("t4.ovf.err", credit_err, 1'b1);
        cpx_fp_grant_cx = 8'h00;
        tick();
        check("t4.sticky.err", credit_err, 1'b1);

        // Contention: add and mul target core 7, which has 1 credit left.
        // rr_last is ADD, so mul wins; after that, both stall.
        add_id = mk_id(7, 1, 17);
        mul_id = mk_id(7, 2, 18);
        add_req = 1'b1;
        check_stall("cont.a", 3'b000);
        tick();
        check("cont.a.dest_rdy", dest_rdy, 3'b001);
        mul_req = 1'b1;
        check_stall("cont.b", 3'b001);
        tick();
        check_out("cont.b", 3'b010, 8'h80, 2'd2, 5'd18);
        check_stall("cont.c", 3'b011);
        tick();
        check("cont.c.dest_rdy", dest_rdy, 3'b000);
        add_req = 1'b0; mul_req = 1'b0;

        // Test 5: reset while mul is stalled on core 6.
        mul_id = mk_id(6, 3, 31);
        mul_req = 1'b1;
        tick(); tick();                           // core 6 credit -> 0
        check_stall("t5.stalled", 3'b010);
        tick();
        grst = 1'b1;
        check_stall("t5.rst", 3'b000);
        tick();
        check_out("t5.rst", 3'b000, 8'h00, 2'd0, 5'd0);
        check("t5.rst.err", credit_err, 1'b0);
        grst = 1'b0;
        check_stall("t5.rel", 3'b000);
        tick();
        check_out("t5.rel", 3'b010, 8'h40, 2'd3, 5'd31);
        mul_req = 1'b0;
        // Core 5 was empty before the reset; its credit is restored now.
        add_id = mk_id(5, 1, 5);
        add_req = 1'b1;
        check_stall("t5.core5", 3'b000);
        tick();
        check_out("t5.core5", 3'b001, 8'h20, 2'd1, 5'd5);
        add_req = 1'b0;

`ifdef FPU_OUT_ARB_STARVE_EN
        // Test 6: add starves on core 4 for 15 cycles. It then beats mul
        // (the round-robin choice) and div.
        add_id = mk_id(4, 0, 8);
        add_req = 1'b1;
        tick(); tick();                           // core 4 credit -> 0
        check("t6.pre.dest_rdy", dest_rdy, 3'b001);
        for (int i = 0; i < 15; i++) begin
            if (i == 14) cpx_fp_grant_cx = 8'h10;
            check_stall($sformatf("t6.s%0d", i), 3'b001);
            tick();
        end
        cpx_fp_grant_cx = 8'h00;
        mul_id = mk_id(1, 1, 1); div_id = mk_id(2, 2, 2);
        mul_req = 1'b1; div_req = 1'b1;
        check_stall("t6.force", 3'b110);
        tick();
        check_out("t6.force", 3'b001, 8'h10, 2'd0, 5'd8);
        add_req = 1'b0; mul_req = 1'b0; div_req = 1'b0;
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
